// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE Z store path: element formats, store configuration, FSM encoding.
package redmule_pkg;

  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:          return 32;
      FP64:          return 64;
      FP16, FP16ALT: return 16;
      default:       return 8;
    endcase
  endfunction

  localparam int unsigned ARRAY_WIDTH = 12;
  localparam int unsigned Z_DW        = 288;
  localparam int unsigned Z_ADDR_W    = 32;
  localparam int unsigned Z_D         = Z_DW / fp_width(FP16);

  typedef struct packed {
    logic [Z_ADDR_W-1:0]            base_addr;
    logic [Z_ADDR_W-1:0]            row_stride;
    logic [Z_ADDR_W-1:0]            tile_stride;
    logic [$clog2(ARRAY_WIDTH):0]   rows;
    logic [$clog2(Z_D):0]           cols;
    logic [15:0]                    n_tiles;
  } z_store_cfg_t;

  typedef logic [1:0] z_store_state_e;
  localparam z_store_state_e Z_IDLE   = 2'd0;
  localparam z_store_state_e Z_RUN    = 2'd1;
  localparam z_store_state_e Z_DRAIN  = 2'd2;
  localparam z_store_state_e Z_FINISH = 2'd3;

endpackage

// File: rtl/redmule_z_store_ctrl_if.sv
// Z-row input handshake plus TCDM write-request bus of the Z store controller.
interface redmule_z_store_ctrl_if #(
  parameter int unsigned DW    = 288,
  parameter int unsigned AddrW = 32
);
  logic [DW-1:0]    z_data;
  logic             z_valid;
  logic             z_ready;
  logic             mem_req;
  logic             mem_gnt;
  logic [AddrW-1:0] mem_addr;
  logic [DW-1:0]    mem_data;
  logic [DW/8-1:0]  mem_strb;

  modport master (
    input  z_data, z_valid, mem_gnt,
    output z_ready, mem_req, mem_addr, mem_data, mem_strb
  );

  modport slave (
    output z_data, z_valid, mem_gnt,
    input  z_ready, mem_req, mem_addr, mem_data, mem_strb
  );
endinterface

// File: rtl/redmule_z_store_slice.sv
// Output stage for Z write requests: single register, or a 2-entry skid buffer
// when REDMULE_Z_STORE_SKID_EN is defined (ready then ignores gnt).
module redmule_z_store_slice #(
  parameter int unsigned PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_req,
  input  logic          out_gnt,
  output logic [PW-1:0] out_data,
  output logic          out_last
);

`ifdef REDMULE_Z_STORE_SKID_EN
  logic [1:0]    cnt;
  logic [PW-1:0] e0, e1;
  logic          push, pop;

  assign in_ready = (cnt != 2'd2);
  assign out_req  = (cnt != 2'd0);
  assign out_data = e0;
  assign out_last = (cnt == 2'd1);
  assign push     = in_valid && in_ready;
  assign pop      = out_req && out_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= 2'd0; e0 <= '0; e1 <= '0;
    end else if (clear_i) begin
      cnt <= 2'd0; e0 <= '0; e1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= in_data;
          else             e1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        // push+pop only possible with 1 or 2 held; 2 blocks push, so cnt==1 here
        2'b11: e0 <= in_data;
        default: ;
      endcase
    end
  end
`else
  logic          vld;
  logic [PW-1:0] q;

  assign in_ready = !vld || out_gnt;
  assign out_req  = vld;
  assign out_data = q;
  assign out_last = vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld <= 1'b0; q <= '0;
    end else if (clear_i) begin
      vld <= 1'b0; q <= '0;
    end else if (in_valid && in_ready) begin
      vld <= 1'b1; q <= in_data;
    end else if (out_gnt) begin
      vld <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/redmule_z_store_ctrl.sv
// Turns finished Z rows into TCDM write requests (address walk + column strobe) and
// signals matrix completion. REDMULE_Z_STORE_SKID_EN selects the skid output stage.
module redmule_z_store_ctrl
  import redmule_pkg::*;
#(
  parameter int unsigned DW       = Z_DW,
  parameter fp_format_e  FpFormat = FP16,
  parameter int unsigned Width    = ARRAY_WIDTH,
  parameter int unsigned AddrW    = Z_ADDR_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  z_store_cfg_t                  cfg_i,
  redmule_z_store_ctrl_if.master        bus,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned BITW = fp_width(FpFormat);
  localparam int unsigned D    = DW / BITW;
  localparam int unsigned BB   = BITW / 8;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned RW   = $clog2(Width) + 1;
  localparam int unsigned CW   = $clog2(D) + 1;
  localparam int unsigned PW   = AddrW + DW + SW;

  z_store_state_e state;
  logic [RW-1:0]    row_cnt, rows_last;
  logic [15:0]      tile_cnt, tiles_last;
  logic [AddrW-1:0] row_addr, tile_addr, row_stride, tile_stride;
  logic [SW-1:0]    strb_q, strb_d;
  logic [CW-1:0]    cols_eff;
  logic             done_q, z_hs, slc_ready, slc_last;
  logic [PW-1:0]    slc_out;

  assign bus.z_ready = (state == Z_RUN) && slc_ready;
  assign z_hs        = bus.z_valid && bus.z_ready;
  assign busy_o      = (state != Z_IDLE);
  assign done_o      = done_q;

  // Column mask is fixed per job, so it is derived once from cfg_i at start.
  always_comb begin
    cols_eff = (cfg_i.cols == '0 || cfg_i.cols > CW'(D)) ? CW'(D) : cfg_i.cols;
    strb_d   = '0;
    for (int unsigned e = 0; e < D; e++)
      if (e < 32'(cols_eff)) strb_d[e*BB +: BB] = '1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= Z_IDLE; row_cnt <= '0; tile_cnt <= '0; rows_last <= '0; tiles_last <= '0;
      row_addr <= '0; tile_addr <= '0; row_stride <= '0; tile_stride <= '0;
      strb_q <= '0; done_q <= 1'b0;
    end else if (clear_i) begin
      state <= Z_IDLE; row_cnt <= '0; tile_cnt <= '0; rows_last <= '0; tiles_last <= '0;
      row_addr <= '0; tile_addr <= '0; row_stride <= '0; tile_stride <= '0;
      strb_q <= '0; done_q <= 1'b0;
    end else begin
      case (state)
        Z_IDLE: if (start_i) begin
          row_stride  <= cfg_i.row_stride;
          tile_stride <= cfg_i.tile_stride;
          row_addr    <= cfg_i.base_addr;
          tile_addr   <= cfg_i.base_addr;
          row_cnt     <= '0;
          tile_cnt    <= '0;
          rows_last   <= (cfg_i.rows == '0) ? '0 : cfg_i.rows - 1'b1;
          tiles_last  <= cfg_i.n_tiles - 16'd1;
          strb_q      <= strb_d;
          state       <= (cfg_i.n_tiles == 16'd0) ? Z_FINISH : Z_RUN;
        end
        Z_RUN: if (z_hs) begin
          if (row_cnt == rows_last) begin
            row_cnt   <= '0;
            tile_cnt  <= tile_cnt + 16'd1;
            tile_addr <= tile_addr + tile_stride;
            row_addr  <= tile_addr + tile_stride;
            if (tile_cnt == tiles_last) state <= Z_DRAIN;
          end else begin
            row_cnt  <= row_cnt + 1'b1;
            row_addr <= row_addr + row_stride;
          end
        end
        // done is raised on the final grant itself so it lands the very next cycle
        Z_DRAIN: if (bus.mem_req && bus.mem_gnt && slc_last) begin
          state  <= Z_FINISH;
          done_q <= 1'b1;
        end
        // entered without done_q only from an empty job: spend one cycle, then pulse
        Z_FINISH: begin
          if (done_q) begin
            done_q <= 1'b0;
            state  <= Z_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state <= Z_IDLE;
      endcase
    end
  end

  redmule_z_store_slice #(.PW(PW)) i_slice (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .in_valid (bus.z_valid && (state == Z_RUN)),
    .in_ready (slc_ready),
    .in_data  ({row_addr, bus.z_data, strb_q}),
    .out_req  (bus.mem_req),
    .out_gnt  (bus.mem_gnt),
    .out_data (slc_out),
    .out_last (slc_last)
  );

  assign {bus.mem_addr, bus.mem_data, bus.mem_strb} = slc_out;

endmodule

// File: tb/tb_redmule_z_store_ctrl.sv
// Bench for redmule_z_store_ctrl: queue-based request model checked every cycle plus directed literals.
module tb_redmule_z_store_ctrl;
  import redmule_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0;
  logic busy, done;
  z_store_cfg_t cfg;

  always #5 clk = ~clk;

  redmule_z_store_ctrl_if #(.DW(288), .AddrW(32)) bus ();

  redmule_z_store_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .cfg_i(cfg), .bus(bus), .busy_o(busy), .done_o(done)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [287:0] data;
    logic [35:0]  strb;
  } txn_t;

  txn_t         q[$];
  logic [31:0]  la[$];
  logic [35:0]  ls[$];
  int           lc[$];
  int total = 0, bad = 0, cyc = 0;
  int done_due = -1, done_cyc = -1, st_cyc = 0;
  int m_k = 0, m_pop = 0, m_total = 0, gnt_mode = 0, hold = 0;
  bit m_active = 1'b0;
  z_store_cfg_t m_cfg;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic z_store_cfg_t mk_cfg(input logic [31:0] base, input logic [31:0] rs,
                                          input logic [31:0] ts, input int rows, input int cols,
                                          input int n);
    z_store_cfg_t c;
    c.base_addr = base; c.row_stride = rs; c.tile_stride = ts;
    c.rows = rows[4:0]; c.cols = cols[5:0]; c.n_tiles = n[15:0];
    return c;
  endfunction

  function automatic int rows_eff(input z_store_cfg_t c);
    return (c.rows == 0) ? 1 : int'(c.rows);
  endfunction

  function automatic logic [35:0] mask(input int cols);
    logic [35:0] m = '0;
    int ce = (cols == 0 || cols > 18) ? 18 : cols;
    for (int e = 0; e < ce; e++) m[2*e +: 2] = 2'b11;
    return m;
  endfunction

  function automatic logic [31:0] m_addr(input int k);
    int re = rows_eff(m_cfg);
    return m_cfg.base_addr + 32'(k / re) * m_cfg.tile_stride + 32'(k % re) * m_cfg.row_stride;
  endfunction

  function automatic logic [287:0] rand_row();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // grant driver: 0 = always grant, 1 = hold 2nd request for 3 cycles, 2 = never grant
  initial begin
    bus.mem_gnt = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (gnt_mode)
        0: bus.mem_gnt = 1'b1;
        1: if (m_pop == 1 && hold < 3) begin bus.mem_gnt = 1'b0; hold++; end
           else bus.mem_gnt = 1'b1;
        default: bus.mem_gnt = 1'b0;
      endcase
    end
  end

  // per-cycle compare against the model
  initial forever begin
    logic exp_rdy;
    txn_t t;
    @(negedge clk);
    if (rst_n) begin
`ifdef REDMULE_Z_STORE_SKID_EN
      exp_rdy = m_active && (m_k < m_total) && (q.size() < 2);
`else
      exp_rdy = m_active && (m_k < m_total) && (q.size() == 0 || bus.mem_gnt);
`endif
      chk("z_ready", bus.z_ready, exp_rdy);
      chk("mem_req", bus.mem_req, q.size() > 0);
      if (q.size() > 0 && bus.mem_req) begin
        t = q[0];
        chk("mem_addr", bus.mem_addr, t.addr);
        chk("mem_strb", bus.mem_strb, t.strb);
        chk("mem_data", bus.mem_data, t.data);
      end
      chk("done", done, cyc == done_due);
      chk("busy", busy, m_active);
      if (done) done_cyc = cyc;
      if (bus.mem_req && bus.mem_gnt && q.size() > 0) begin
        la.push_back(bus.mem_addr); ls.push_back(bus.mem_strb); lc.push_back(cyc);
        void'(q.pop_front());
        m_pop++;
        if (m_pop == m_total && m_k == m_total) done_due = cyc + 1;
      end
      if (bus.z_valid && bus.z_ready) begin
        if (m_k >= m_total) begin
          total++; bad++;
          $display("FAIL z_extra_accept: got row %0d want at most %0d", m_k + 1, m_total);
        end else begin
          t.addr = m_addr(m_k); t.data = bus.z_data; t.strb = mask(int'(m_cfg.cols));
          q.push_back(t);
        end
        m_k++;
      end
      if (cyc == done_due) m_active = 1'b0;
    end
  end

  // all driver tasks start and end 1 time unit after a rising edge
  task automatic start_run(input z_store_cfg_t c);
    start = 1'b1; cfg = c;
    m_cfg = c; m_k = 0; m_pop = 0; hold = 0;
    m_total = int'(c.n_tiles) * rows_eff(c);
    la.delete(); ls.delete(); lc.delete();
    done_cyc = -1; st_cyc = cyc;
    done_due = (c.n_tiles == 0) ? cyc + 2 : -1;
    @(posedge clk); #1;
    start = 1'b0; m_active = 1'b1;
  endtask

  task automatic feed(input int n);
    int sent = 0, guard = 0;
    logic hs;
    bus.z_data = rand_row(); bus.z_valid = 1'b1;
    while (sent < n && guard < 200) begin
      @(negedge clk); hs = bus.z_ready;
      @(posedge clk); #1;
      guard++;
      if (hs) begin sent++; bus.z_data = rand_row(); end
    end
    bus.z_valid = 1'b0;
    if (sent < n) begin
      total++; bad++;
      $display("FAIL feed_timeout: got %0d rows accepted want %0d", sent, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (m_active && n < 300) begin @(posedge clk); #1; n++; end
    total++;
    if (m_active) begin
      bad++;
      $display("FAIL %s: got no done within %0d cycles want done", name, n);
      m_active = 1'b0;
    end
  endtask

  logic [31:0] t1_addr [8];

  initial begin
    t1_addr = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0, 32'h1400, 32'h1440, 32'h1480, 32'h14C0};
    bus.z_valid = 1'b1; bus.z_data = '0; cfg = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_data", bus.mem_data, 288'h0);
    chk("rst_mem_strb", bus.mem_strb, 36'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_z_ready", bus.z_ready, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_z_ready", bus.z_ready, 1'b0);
    @(posedge clk); #1 bus.z_valid = 1'b0;

    // two full tiles at full throughput
    start_run(mk_cfg(32'h1000, 32'h40, 32'h400, 4, 18, 2));
    feed(8);
    wait_idle("t1_done");
    chk("t1_count", la.size(), 8);
    for (int i = 0; i < la.size() && i < 8; i++) begin
      chk("t1_addr", la[i], t1_addr[i]);
      chk("t1_strb", ls[i], 36'hF_FFFF_FFFF);
      chk("t1_b2b", lc[i], lc[0] + i);
    end
    if (lc.size() == 8) chk("t1_done_cycle", done_cyc, lc[7] + 1);

    // leftover columns, then cols==0
    start_run(mk_cfg(32'h100, 32'h0, 32'h0, 1, 5, 1));
    feed(1);
    wait_idle("cols5_done");
    chk("cols5_count", ls.size(), 1);
    if (ls.size() > 0) chk("cols5_strb", ls[0], 36'h3FF);
    start_run(mk_cfg(32'h200, 32'h0, 32'h0, 0, 0, 1));
    feed(1);
    wait_idle("cols0_done");
    if (ls.size() > 0) chk("cols0_strb", ls[0], 36'hF_FFFF_FFFF);

    // backpressure on the 2nd request
    gnt_mode = 1;
    start_run(mk_cfg(32'h8000, 32'h20, 32'h200, 4, 9, 1));
    feed(4);
    wait_idle("bp_done");
    gnt_mode = 0;
    chk("bp_count", la.size(), 4);
    if (la.size() == 4) begin
      chk("bp_addr1", la[1], 32'h8020);
      chk("bp_hold", lc[1] - lc[0], 4);
      chk("bp_addr3", la[3], 32'h8060);
    end

    // empty job
    start_run(mk_cfg(32'h4000, 32'h40, 32'h400, 4, 18, 0));
    wait_idle("zero_done");
    chk("zero_done_cycle", done_cyc, st_cyc + 2);
    chk("zero_no_req", la.size(), 0);

    // clear while a request is pending
    gnt_mode = 2;
    start_run(mk_cfg(32'h3000, 32'h40, 32'h400, 4, 18, 1));
    feed(1);
    repeat (2) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    q.delete(); m_active = 1'b0; m_total = 0; m_k = 0; m_pop = 0; done_due = -1;
    @(negedge clk);
    chk("clr_mem_req", bus.mem_req, 1'b0);
    chk("clr_busy", busy, 1'b0);
    @(posedge clk); #1;
    gnt_mode = 0;

    // restart with a new configuration
    start_run(mk_cfg(32'h2000_0000, 32'h10, 32'h100, 2, 20, 2));
    feed(4);
    wait_idle("restart_done");
    chk("restart_count", la.size(), 4);
    if (la.size() == 4) begin
      chk("restart_addr0", la[0], 32'h2000_0000);
      chk("restart_addr3", la[3], 32'h2000_0110);
      chk("restart_strb", ls[0], 36'hF_FFFF_FFFF);
    end

    // start during RUN is ignored; address wraps modulo 2^32
    start_run(mk_cfg(32'hFFFF_FF80, 32'h40, 32'h100, 4, 7, 1));
    feed(2);
    start = 1'b1; cfg = mk_cfg(32'h5555_0000, 32'h8, 32'h8, 1, 1, 0);
    @(posedge clk); #1;
    start = 1'b0;
    feed(2);
    wait_idle("ign_done");
    chk("ign_count", la.size(), 4);
    if (la.size() == 4) begin
      chk("ign_addr2", la[2], 32'h0);
      chk("ign_addr3", la[3], 32'h40);
      chk("ign_strb", ls[3], 36'h3FFF);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
